// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps a 2-input gate through its four input vectors,
// holds each vector for HOLD_CYCLES clocks, samples the gate output on the
// last cycle of each hold and records which vectors disagree with TRUTH.
module gate_vector_checker #(
  parameter int unsigned HOLD_CYCLES = 20,
  parameter logic [3:0]  TRUTH       = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned VEC_W = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(3);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [VEC_W-1:0] vec, vec_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [2:0]       err_nxt, err_sum;
  logic [3:0]       fail_nxt;
  logic             mismatch_c;

  // q is only consulted on the last cycle of a hold, so glitches elsewhere are ignored
  assign mismatch_c = (q != TRUTH[vec]);

  // State, counters and all outputs are registered together
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      vec       <= '0;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      cnt       <= cnt_nxt;
      a         <= a_nxt;
      b         <= b_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      pass      <= pass_nxt;
      err_count <= err_nxt;
      fail_vec  <= fail_nxt;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE sweep
  always_comb begin
    state_nxt = state;
    vec_nxt   = vec;
    cnt_nxt   = cnt;
    a_nxt     = a;
    b_nxt     = b;
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fail_nxt  = fail_vec;
    err_sum   = err_count;

    case (state)
      S_IDLE, S_DONE: begin
        // A start from DONE discards the previous results, same as from IDLE
        if (start) begin
          state_nxt = S_RUN;
          vec_nxt   = '0;
          cnt_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = '0;
          fail_nxt  = '0;
        end
      end

      S_RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          err_sum  = err_count + 3'(mismatch_c);
          err_nxt  = err_sum;
          fail_nxt = fail_vec | (4'(mismatch_c) << vec);
          if (vec == VEC_LAST) begin
            state_nxt = S_DONE;
            vec_nxt   = '0;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_sum == 3'd0);
          end else begin
            vec_nxt = vec + VEC_W'(1);
            a_nxt   = vec_nxt[1];
            b_nxt   = vec_nxt[0];
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = S_IDLE;
        vec_nxt   = '0;
        cnt_nxt   = '0;
        a_nxt     = 1'b0;
        b_nxt     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        pass_nxt  = 1'b0;
        err_nxt   = '0;
        fail_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Testbench for gate_vector_checker: two instances (NOR/20-cycle hold and
// NAND/2-cycle hold), scoreboard of expected sweep results, per-cycle monitor.
module tb_gate_vector_checker;

  localparam int M_GATE = 0;
  localparam int M_TIE0 = 1;
  localparam int M_TIE1 = 2;
  localparam int M_RAND = 3;

  localparam logic [3:0] T0 = 4'b0001;
  localparam logic [3:0] T1 = 4'b0111;

  typedef struct {
    int         d;
    int         done_cyc;
    logic [3:0] fail;
    logic [2:0] err;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst     [2];
  logic       start   [2];
  logic       q_s     [2];
  logic       q_drv   [2];
  logic       a_s     [2];
  logic       b_s     [2];
  logic       busy_s  [2];
  logic       done_s  [2];
  logic       pass_s  [2];
  logic [2:0] err_s   [2];
  logic [3:0] fail_s  [2];
  logic       rst_q   [2];
  logic       done_prev [2];
  logic [7:0] res_hold  [2];

  int         mode_r    [2];
  logic [3:0] mask_r    [2];
  int         run_start [2];
  bit         run_active[2];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gate_vector_checker #(.HOLD_CYCLES(20), .TRUTH(T0)) dut0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .q(q_s[0]),
    .a(a_s[0]), .b(b_s[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fail_s[0])
  );

  gate_vector_checker #(.HOLD_CYCLES(2), .TRUTH(T1)) dut1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .q(q_s[1]),
    .a(a_s[1]), .b(b_s[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fail_s[1])
  );

  function automatic int hold_of(input int d);
    return (d == 0) ? 20 : 2;
  endfunction

  function automatic logic [3:0] truth_of(input int d);
    return (d == 0) ? T0 : T1;
  endfunction

  // Reference: a vector fails when the value seen at its sampling edge differs from the truth table
  function automatic logic [3:0] exp_fail(input int d, input int mode, input logic [3:0] mask);
    logic [3:0] t;
    logic [3:0] s;
    t = truth_of(d);
    case (mode)
      M_TIE0:  s = 4'h0;
      M_TIE1:  s = 4'hf;
      M_RAND:  s = t ^ mask;
      default: s = t;
    endcase
    return s ^ t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Gate under test: real gate in GATE mode, otherwise the driver's value
  assign q_s[0] = (mode_r[0] == M_GATE) ? T0[{a_s[0], b_s[0]}] : q_drv[0];
  assign q_s[1] = (mode_r[1] == M_GATE) ? T1[{a_s[1], b_s[1]}] : q_drv[1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int d = 0; d < 2; d++) rst_q[d] <= rst[d];
  end

  // q driver: ties, or random glitches except on the cycle feeding a sampling edge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int j;
      int h;
      int k;
      logic [3:0] t;
      j = cyc - run_start[d];
      h = hold_of(d);
      t = truth_of(d);
      case (mode_r[d])
        M_TIE0: q_drv[d] = 1'b0;
        M_TIE1: q_drv[d] = 1'b1;
        M_RAND: begin
          if (run_active[d] && j >= 0 && ((j + 1) % h) == 0 && ((j + 1) / h) <= 4) begin
            k = (j + 1) / h - 1;
            q_drv[d] = t[k] ^ mask_r[d][k];
          end else begin
            q_drv[d] = 1'($urandom);
          end
        end
        default: q_drv[d] = 1'($urandom);
      endcase
    end
  end

  // Monitor: reset state, per-cycle run outputs, done timing/results, DONE stability
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int j;
      int h;
      logic [1:0] vv;
      exp_t e;
      j = cyc - run_start[d];
      h = hold_of(d);
      if (rst_q[d]) begin
        chk("reset_outputs", {a_s[d], b_s[d], busy_s[d], done_s[d], pass_s[d], err_s[d], fail_s[d]}, 0);
      end else begin
        if (run_active[d] && j >= 0 && j < 4 * h) begin
          vv = 2'(j / h);
          chk("run_ctrl_ab", {busy_s[d], done_s[d], pass_s[d], a_s[d], b_s[d]}, {3'b100, vv});
          if (j < h) chk("run_results_cleared", {err_s[d], fail_s[d]}, 0);
        end
        if (done_s[d] === 1'b1 && done_prev[d] === 1'b0) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("done_dut", d, e.d);
            chk("done_cycle", cyc, e.done_cyc);
            chk("done_fail_vec", fail_s[d], e.fail);
            chk("done_err_count", err_s[d], e.err);
            chk("done_pass", pass_s[d], e.pass);
            chk("done_idle_outs", {busy_s[d], a_s[d], b_s[d]}, 0);
          end
          res_hold[d] = {pass_s[d], err_s[d], fail_s[d]};
        end else if (done_s[d] === 1'b1) begin
          chk("done_stable", {busy_s[d], a_s[d], b_s[d], pass_s[d], err_s[d], fail_s[d]},
              {3'b000, res_hold[d]});
        end
      end
      done_prev[d] = done_s[d];
    end
  end

  task automatic begin_run(input int d, input int mode, input logic [3:0] mask);
    exp_t e;
    logic [3:0] f;
    @(posedge clk); #2;
    mode_r[d] = mode;
    mask_r[d] = mask;
    f = exp_fail(d, mode, mask);
    e.d        = d;
    e.done_cyc = cyc + 1 + 4 * hold_of(d);
    e.fail     = f;
    e.err      = 3'($countones(f));
    e.pass     = (f == 4'h0);
    exp_q.push_back(e);
    run_start[d]  = cyc + 1;
    run_active[d] = 1'b1;
    start[d]      = 1'b1;
    @(posedge clk); #2;
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * hold_of(d) + 8; i++) begin
      @(posedge clk); #2;
      if (cyc >= run_start[d] + 4 * hold_of(d) && done_s[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  // Return just after the edge preceding run cycle jj
  task automatic wait_j(input int d, input int jj);
    for (int i = 0; i < 4 * hold_of(d) + 8; i++) begin
      if (cyc - run_start[d] >= jj - 1) break;
      @(posedge clk); #2;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d]    = 1'b1;
      start[d]  = 1'b0;
      mode_r[d] = M_GATE;
      mask_r[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // NOR, real gate, then tied-low and tied-high outputs
    begin_run(0, M_GATE, 4'h0); wait_done(0);
    begin_run(0, M_TIE0, 4'h0); wait_done(0);
    begin_run(0, M_TIE1, 4'h0); wait_done(0);

    // Second start mid-sweep is ignored
    begin_run(0, M_GATE, 4'h0);
    wait_j(0, 40);
    start[0] = 1'b1;
    @(posedge clk); #2;
    start[0] = 1'b0;
    wait_done(0);

    // Reset mid-sweep aborts, then a normal sweep follows
    begin_run(0, M_GATE, 4'h0);
    wait_j(0, 30);
    rst[0]        = 1'b1;
    run_active[0] = 1'b0;
    void'(exp_q.pop_back());
    @(posedge clk); #2;
    rst[0] = 1'b0;
    begin_run(0, M_GATE, 4'h0); wait_done(0);

    // NAND with short hold; restart from DONE clears previous failures
    begin_run(1, M_GATE, 4'h0); wait_done(1);
    begin_run(1, M_TIE1, 4'h0); wait_done(1);
    begin_run(1, M_GATE, 4'h0); wait_done(1);

    // Random per-vector faults with glitching q between sampling edges
    for (int r = 0; r < 10; r++) begin
      begin_run(r % 2, M_RAND, 4'($urandom));
      wait_done(r % 2);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 20, SHALL set the number of clock cycles each input vector is held; legal range 2..255.
REQ-002 Parameter TRUTH, 4 bits, default 4'b0001 (NOR), SHALL hold the expected output, indexed by {a,b}.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle request to run the four-vector sweep.
REQ-006 Port q  input  1  output of the 2-input gate under test.
REQ-007 Port a  output  1  gate input A; the MSB of the vector index.
REQ-008 Port b  output  1  gate input B; the LSB of the vector index.
REQ-009 Port busy  output  1  high while the sweep is running.
REQ-010 Port done  output  1  high from sweep completion until the next start or reset.
REQ-011 Port pass  output  1  high in DONE when err_count is zero.
REQ-012 Port err_count  output  3  number of mismatching vectors, 0..4.
REQ-013 Port fail_vec  output  4  bit k is set when vector k mismatched.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 The block SHALL hold an internal 2-bit vector index vec and a hold counter cnt, 0..HOLD_CYCLES-1.
REQ-016 IDLE transition: when start=1 at an edge, the block SHALL, after that edge:
- enter RUN with vec=0 and cnt=0;
- set busy=1 and done=0;
- clear err_count and fail_vec.
REQ-017 In RUN, a and b SHALL equal vec[1] and vec[0] and SHALL be registered, with no combinational path from any input.
REQ-018 In RUN, cnt SHALL increment at every edge; at the edge where cnt==HOLD_CYCLES-1 the block SHALL:
- sample q;
- compare q against TRUTH[vec];
- reset cnt to 0.
REQ-019 On a mismatch, err_count SHALL increment by 1 and fail_vec[vec] SHALL be set at the same edge.
REQ-020 At the sampling edge, when vec<3, vec SHALL increment.
REQ-021 At the sampling edge, when vec==3, the block SHALL enter DONE with:
- busy=0, done=1, a=0, b=0;
- pass equal to (final err_count==0).
REQ-022 Vector k SHALL be driven for exactly HOLD_CYCLES cycles.
REQ-023 done SHALL rise exactly 4*HOLD_CYCLES edges after the start edge.
REQ-024 start SHALL be ignored while in RUN.
REQ-025 In DONE, all results SHALL remain stable.
REQ-026 start=1 in DONE SHALL behave as start in IDLE: clear the results and begin a new sweep at vec=0.
REQ-027 q SHALL be read only at sampling edges; glitches between sampling edges SHALL have no effect.
REQ-028 pass SHALL be 0 in IDLE and in RUN.
REQ-029 err_count SHALL never exceed 4, since one compare happens per vector.

Reset
REQ-030 With rst=1 at an edge, the block SHALL enter IDLE with all outputs 0: a, b, busy, done, pass, err_count and fail_vec.
REQ-031 With rst=1 at an edge, vec and cnt SHALL be 0.
REQ-032 rst SHALL take priority over start and over any RUN activity, including an edge that would otherwise sample.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep with no partial result retained.

Verification
REQ-034 NOR gate wired to a/b/q, defaults, start pulse:
- a,b step 00,01,10,11, each held 20 cycles;
- done=1 at start edge+80;
- pass=1, err_count=0, fail_vec=0000.
REQ-035 q tied 0, defaults: err_count=1, fail_vec=0001, pass=0.
REQ-036 q tied 1, defaults: err_count=3, fail_vec=1110, pass=0.
REQ-037 start pulsed again at cycle 40 of a run: ignored, and done still occurs at +80; rst=1 at cycle 30 of a new run: all outputs 0 next cycle, and a later start completes a normal sweep.
REQ-038 HOLD_CYCLES=2, NAND gate, TRUTH=4'b0111:
- done at start+8, pass=1;
- start in DONE clears err_count and fail_vec and reruns.
